// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: per-channel toggle or pulse output plus wrap tick.
// Optional CLK_DIV_SYNC_EN adds a sync_all input that realigns every channel.
module clk_div_multi #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 20,
    parameter int DIV_DEFAULT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic             div_load,
    input  logic [2:0]       div_ch,
    input  logic [CNT_W-1:0] div_val,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_all,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic sync;

`ifdef CLK_DIV_SYNC_EN
    assign sync = sync_all;
`else
    assign sync = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic             mode_q;
        logic             co;
        logic             tk;
        logic             sel;
        logic             chg;
        logic             wrap;

        assign sel  = div_load && (div_ch == 3'(i));
        assign chg  = mode[i] != mode_q;
        // Load, mode change and sync all restart the count and veto the wrap
        assign wrap = en[i] && (cnt == div) && !sel && !chg && !sync;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                div    <= DIV_RST;
                mode_q <= 1'b0;
                co     <= 1'b0;
                tk     <= 1'b0;
            end else begin
                mode_q <= mode[i];
                tk     <= wrap;
                if (sel && !sync)
                    div <= div_val;
                if (sync || chg || sel)
                    cnt <= '0;
                else if (en[i])
                    cnt <= wrap ? '0 : cnt + 1'b1;
                if (sync || chg)
                    co <= 1'b0;
                else if (mode_q)
                    co <= wrap;
                else if (wrap)
                    co <= ~co;
            end
        end

        assign clk_out[i] = co;
        assign tick[i]    = tk;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed bench for clk_div_multi (NCH=2, CNT_W=8, DIV_DEFAULT=3).
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en;
    logic [1:0] mode;
    logic       div_load;
    logic [2:0] div_ch;
    logic [7:0] div_val;
    logic       sync_all;
    logic [1:0] clk_out;
    logic [1:0] tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_cnt [2];
    logic [7:0] m_div [2];
    logic [1:0] m_mode;
    logic [1:0] m_out;
    logic [1:0] m_tick;

    always #5 clk = ~clk;

    clk_div_multi #(.NCH(2), .CNT_W(8), .DIV_DEFAULT(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .div_load(div_load),
        .div_ch  (div_ch),
        .div_val (div_val),
`ifdef CLK_DIV_SYNC_EN
        .sync_all(sync_all),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Reference: one clock edge of each channel, rules in priority order
    task automatic model();
        for (int i = 0; i < 2; i++) begin
            bit ld;
            ld = div_load && (int'(div_ch) == i);
            if (reset) begin
                m_cnt[i] = 0; m_div[i] = 3; m_mode[i] = 0;
                m_out[i] = 0; m_tick[i] = 0;
            end else begin
                if (sync_all) begin
                    m_cnt[i] = 0; m_out[i] = 0; m_tick[i] = 0;
                end else if (mode[i] != m_mode[i]) begin
                    m_cnt[i] = 0; m_out[i] = 0; m_tick[i] = 0;
                    if (ld) m_div[i] = div_val;
                end else if (ld) begin
                    m_div[i] = div_val; m_cnt[i] = 0; m_tick[i] = 0;
                    if (m_mode[i]) m_out[i] = 0;
                end else if (!en[i]) begin
                    m_tick[i] = 0;
                    if (m_mode[i]) m_out[i] = 0;
                end else if (m_cnt[i] == m_div[i]) begin
                    m_cnt[i] = 0; m_tick[i] = 1;
                    m_out[i] = m_mode[i] ? 1'b1 : ~m_out[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
                    if (m_mode[i]) m_out[i] = 0;
                end
                m_mode[i] = mode[i];
            end
        end
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; en = 0; mode = 0; div_load = 0; div_ch = 0;
        div_val = 0; sync_all = 0;
        step(); step();
        n_cmp++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            n_bad++;
            $display("FAIL reset: clk_out=%b tick=%b expected 00 00", clk_out, tick);
        end
        n_cmp++;
        if (clk_out !== m_out || tick !== m_tick) begin
            n_bad++;
            $display("FAIL reset_model: %b %b expected %b %b", clk_out, tick, m_out, m_tick);
        end
    endtask

    task automatic test_toggle();
        int tg0 = 0, tg1 = 0, tk0 = 0;
        logic [1:0] prev;
        reset = 0; en = 2'b11;
        prev = clk_out;
        for (int c = 0; c < 24; c++) begin
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL toggle cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
            if (clk_out[0] !== prev[0]) tg0++;
            if (clk_out[1] !== prev[1]) tg1++;
            if (tick[0] === 1'b1) tk0++;
            prev = clk_out;
        end
        n_cmp++;
        if (tg0 != 6 || tg1 != 6 || tk0 != 6) begin
            n_bad++;
            $display("FAIL toggle_count: %0d %0d %0d expected 6 6 6", tg0, tg1, tk0);
        end
    endtask

    task automatic test_pulse();
        int p = 0;
        mode = 2'b10;
        step();
        n_cmp++;
        if (clk_out[1] !== 1'b0 || clk_out !== m_out || tick !== m_tick) begin
            n_bad++;
            $display("FAIL pulse_clear: %b %b expected %b %b", clk_out, tick, m_out, m_tick);
        end
        for (int c = 0; c < 16; c++) begin
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL pulse cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
            if (clk_out[1] === 1'b1) p++;
        end
        n_cmp++;
        if (p != 4) begin
            n_bad++;
            $display("FAIL pulse_count: %0d expected 4", p);
        end
    endtask

    task automatic test_load();
        int tg = 0;
        logic prev;
        mode = 2'b00;
        step();
        div_load = 1; div_ch = 0; div_val = 0;
        step();
        div_load = 0;
        prev = clk_out[0];
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL load0 cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
            if (clk_out[0] !== prev) tg++;
            prev = clk_out[0];
        end
        n_cmp++;
        if (tg != 8) begin
            n_bad++;
            $display("FAIL load0_count: %0d expected 8", tg);
        end
        div_load = 1; div_ch = 5; div_val = 7;
        step();
        div_load = 0;
        tg = 0;
        prev = clk_out[0];
        for (int c = 0; c < 6; c++) begin
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL load5 cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
            if (clk_out[0] !== prev) tg++;
            prev = clk_out[0];
        end
        n_cmp++;
        if (tg != 6) begin
            n_bad++;
            $display("FAIL load5_count: %0d expected 6", tg);
        end
    endtask

    task automatic test_load_wrap();
        int guard = 0;
        logic held;
        div_load = 1; div_ch = 0; div_val = 4;
        step();
        div_load = 0;
        while (m_cnt[0] != m_div[0] && guard < 50) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL load_wrap_wait: guard=%0d expected <50", guard);
        end
        held = m_out[0];
        div_load = 1; div_ch = 0; div_val = 2;
        step();
        div_load = 0;
        n_cmp++;
        if (tick[0] !== 1'b0 || clk_out[0] !== held) begin
            n_bad++;
            $display("FAIL load_wrap_edge: tick=%b out=%b expected 0 %b", tick[0], clk_out[0], held);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            n_cmp++;
            if (tick[0] !== (c == 3) || clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL load_wrap cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
        end
    endtask

    task automatic test_enable();
        int guard = 0;
        logic held;
        step(); step();
        held = m_out[0];
        en = 2'b10;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (clk_out[0] !== held || tick[0] !== 1'b0 || clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL hold cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
        end
        en = 2'b11;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL resume cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
        end
        reset = 1;
        step();
        n_cmp++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset: %b %b expected 00 00", clk_out, tick);
        end
        reset = 0;
        while (tick[0] !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard != 4) begin
            n_bad++;
            $display("FAIL first_wrap: after %0d cycles expected 4", guard);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            div_load = ($urandom_range(0, 9) == 0);
            div_ch   = 3'($urandom_range(0, 7));
            div_val  = 8'($urandom_range(0, 5));
`ifdef CLK_DIV_SYNC_EN
            sync_all = ($urandom_range(0, 49) == 0);
`endif
            step();
            n_cmp++;
            if (clk_out !== m_out || tick !== m_tick) begin
                n_bad++;
                $display("FAIL random cyc %0d: %b %b expected %b %b", c, clk_out, tick, m_out, m_tick);
            end
        end
        reset = 0; div_load = 0; sync_all = 0; mode = 0; en = 2'b11;
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        int guard = 0;
        reset = 1; step(); reset = 0;
        en = 2'b01; step(); step();
        en = 2'b11; step(); step(); step();
        sync_all = 1;
        step();
        sync_all = 0;
        n_cmp++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            n_bad++;
            $display("FAIL sync_clear: %b %b expected 00 00", clk_out, tick);
        end
        while (tick === 2'b00 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (tick !== 2'b11 || guard != 4) begin
            n_bad++;
            $display("FAIL sync_align: tick=%b after %0d expected 11 after 4", tick, guard);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_toggle();
        test_pulse();
        test_load();
        test_load_wrap();
        test_enable();
        test_random();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels, range 1..8.
REQ-002 Parameter CNT_W, default 20: counter and divisor width per channel.
REQ-003 Parameter DIV_DEFAULT, default 50000: divisor loaded into every channel at reset; SHALL fit in CNT_W bits.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port reset, input, 1: reset, synchronous and active-high.
REQ-006 Port en, input, NCH: per-channel run enable.
REQ-007 Port mode, input, NCH: per-channel output mode; 0 = toggle (square wave), 1 = pulse (one-cycle strobe).
REQ-008 Port div_load, input, 1: divisor write strobe.
REQ-009 Port div_ch, input, 3: target channel for div_load.
REQ-010 Port div_val, input, CNT_W: divisor value written on div_load.
REQ-011 Port clk_out, output, NCH: registered divided output per channel.
REQ-012 Port tick, output, NCH: registered one-cycle wrap strobe per channel, independent of mode.

Function
REQ-013 Each channel SHALL hold a CNT_W counter cnt, a divisor register div, and a registered copy of mode.
REQ-014 When en[i]=1 and cnt==div, cnt SHALL become 0 and a wrap event SHALL occur; otherwise cnt SHALL increment by 1.
REQ-015 On a wrap event, tick[i] SHALL be 1 for exactly the following cycle; otherwise tick[i] SHALL be 0.
REQ-016 Toggle mode: clk_out[i] SHALL invert on each wrap event, giving a period of 2*(div+1) clk cycles at 50% duty.
REQ-017 Pulse mode: clk_out[i] SHALL equal tick[i], giving a period of div+1 cycles.
REQ-018 When en[i]=0, cnt SHALL hold, tick[i] SHALL be 0, and clk_out[i] SHALL hold in toggle mode and be 0 in pulse mode.
REQ-019 div=0 SHALL be legal: a wrap event occurs every enabled cycle (clk/2 toggle; constant-high pulse).
REQ-020 On div_load=1 with div_ch<NCH, the selected channel's div SHALL take div_val and its cnt SHALL clear to 0 at the same edge. clk_out SHALL be unchanged and no tick SHALL be produced at that edge.
REQ-021 div_load with div_ch>=NCH SHALL be ignored.
REQ-022 When mode[i] differs from the registered mode, that channel SHALL clear cnt, clk_out[i] and tick[i] to 0 and adopt the new mode at the same edge.
REQ-023 Where div_load and a wrap condition coincide on one channel, the load SHALL win and the wrap event SHALL be suppressed.
REQ-024 Channels SHALL be fully independent; the counter SHALL never exceed div, so no CNT_W overflow occurs.

Reset
REQ-025 While reset=1 at a clock edge: every cnt=0, div=DIV_DEFAULT, registered mode=0, clk_out=0, tick=0.
REQ-026 Reset SHALL take priority over div_load, mode change, sync_all and en.
REQ-027 The first wrap after reset release SHALL occur DIV_DEFAULT+1 enabled cycles later.

Configuration
REQ-028 Macro CLK_DIV_SYNC_EN: when defined, an input port sync_all (1 bit) SHALL exist. sync_all=1 SHALL clear all cnt, clk_out and tick to 0 at the next edge, aligning channel phases. It SHALL take priority over div_load and wrap events but not over reset.
REQ-029 Without CLK_DIV_SYNC_EN, the sync_all port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NCH=2, CNT_W=8, DIV_DEFAULT=3)
REQ-030 Reset, then en=2'b11, mode=0 -> clk_out toggles every 4 cycles (period 8) on both channels; tick pulses every 4 cycles.
REQ-031 mode[1]=1 -> ch1 clk_out clears that edge, then gives a 1-cycle pulse every 4 cycles; ch0 is unaffected.
REQ-032 div_load, div_ch=0, div_val=0 -> ch0 toggles every cycle; div_load with div_ch=5 -> no change on either channel.
REQ-033 div_load on ch0 in the exact cycle ch0 cnt==div -> no toggle and no tick; cnt=0; the next wrap occurs div_val+1 cycles later.
REQ-034 en[0]=0 for 5 cycles mid-count -> cnt and clk_out hold; after re-enable, counting resumes from the held cnt. Assert reset mid-count -> all outputs 0 and div=3 next cycle.
REQ-035 With CLK_DIV_SYNC_EN, pulse sync_all with channels at different phases -> both cnt=0 and both clk_out=0; the next wraps coincide when divisors are equal.
